// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: RGB LCD timing generator with a centred input window.
// Produces HS/VS/DE and the panel pixel bus, and issues pixel requests
// REQ_LEAD cycles ahead of display. It also sequences panel reset and
// backlight, and starts/stops only at frame boundaries.
module lcd_timing_gen #(
  parameter int H_SYNC     = 128,
  parameter int H_BACK     = 88,
  parameter int H_DISP     = 800,
  parameter int H_FRONT    = 40,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int V_DISP     = 480,
  parameter int V_FRONT    = 10,
  parameter int WIN_W      = 640,
  parameter int WIN_H      = 480,
  parameter int REQ_LEAD   = 1,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int DATA_W     = 16,
  parameter logic [DATA_W-1:0] BORDER = '0,
  parameter int RST_CYCLES = 1024,
  parameter int CNT_W      = 12
) (
  input  logic              lcd_pclk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] pixel_data,
  output logic              data_req,
  output logic [CNT_W-1:0]  req_x,
  output logic [CNT_W-1:0]  req_y,
  output logic              frame_start,
  output logic              lcd_hs,
  output logic              lcd_vs,
  output logic              lcd_de,
  output logic [DATA_W-1:0] lcd_rgb,
  output logic              lcd_clk,
  output logic              lcd_rst,
  output logic              lcd_bl
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK;
  localparam int VA      = V_SYNC + V_BACK;
  localparam int X0      = HA + (H_DISP - WIN_W) / 2;
  localparam int Y0      = VA + (V_DISP - WIN_H) / 2;

  // Counter-width copies of every decode boundary
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] DE_X0  = CNT_W'(HA);
  localparam logic [CNT_W-1:0] DE_X1  = CNT_W'(HA + H_DISP);
  localparam logic [CNT_W-1:0] DE_Y0  = CNT_W'(VA);
  localparam logic [CNT_W-1:0] DE_Y1  = CNT_W'(VA + V_DISP);
  localparam logic [CNT_W-1:0] WX0    = CNT_W'(X0);
  localparam logic [CNT_W-1:0] WX1    = CNT_W'(X0 + WIN_W);
  localparam logic [CNT_W-1:0] WY0    = CNT_W'(Y0);
  localparam logic [CNT_W-1:0] WY1    = CNT_W'(Y0 + WIN_H);
  localparam logic [CNT_W-1:0] RQ0    = CNT_W'(X0 - REQ_LEAD);
  localparam logic [CNT_W-1:0] RQ1    = CNT_W'(X0 + WIN_W - REQ_LEAD);

  // Power-up counter wide enough to hold RST_CYCLES itself
  localparam int RW = $clog2(RST_CYCLES + 2);
  localparam logic [RW-1:0] RST_END = RW'(RST_CYCLES);
  localparam logic [RW-1:0] RST_PRE = RW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {PWRUP, IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [RW-1:0]    rst_cnt;
  logic             bl_seen;
  logic             last_pix;
  logic             run;

  assign lcd_clk  = lcd_pclk;
  assign last_pix = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign run      = (state == RUN);
  assign lcd_rst  = (rst_cnt == RST_END);
  // Backlight turns on in the same cycle as the first frame_start
  assign lcd_bl   = bl_seen | frame_start;

  // State register
  always_ff @(posedge lcd_pclk) begin
    if (!rst_n) state <= PWRUP;
    else        state <= state_nxt;
  end

  // Next state: leave PWRUP as the reset counter reaches its end, and
  // only stop after the last pixel of a frame
  always_comb begin
    state_nxt = state;
    case (state)
      PWRUP:   if (rst_cnt >= RST_PRE) state_nxt = IDLE;
      IDLE:    if (enable)             state_nxt = RUN;
      RUN:     if (last_pix && !enable) state_nxt = IDLE;
      default: state_nxt = PWRUP;
    endcase
  end

  // Panel reset timer; saturates at RST_CYCLES
  always_ff @(posedge lcd_pclk) begin
    if (!rst_n)                 rst_cnt <= '0;
    else if (rst_cnt != RST_END) rst_cnt <= rst_cnt + 1'b1;
  end

  // Raster counters; held at 0 outside RUN so every run starts at (0,0)
  always_ff @(posedge lcd_pclk) begin
    if (!rst_n || !run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Backlight latch, cleared only by reset
  always_ff @(posedge lcd_pclk) begin
    if (!rst_n)           bl_seen <= 1'b0;
    else if (frame_start) bl_seen <= 1'b1;
  end

  // Output decode from the registered counters; idle values outside RUN
  always_comb begin
    logic de_h, de_v, win_h, win_v, rq_h;
    de_h  = (h_cnt >= DE_X0) && (h_cnt < DE_X1);
    de_v  = (v_cnt >= DE_Y0) && (v_cnt < DE_Y1);
    win_h = (h_cnt >= WX0)   && (h_cnt < WX1);
    win_v = (v_cnt >= WY0)   && (v_cnt < WY1);
    rq_h  = (h_cnt >= RQ0)   && (h_cnt < RQ1);

    lcd_hs      = ~HS_POL;
    lcd_vs      = ~VS_POL;
    lcd_de      = 1'b0;
    lcd_rgb     = '0;
    data_req    = 1'b0;
    req_x       = '0;
    req_y       = '0;
    frame_start = 1'b0;

    if (run) begin
      lcd_hs      = (h_cnt < HS_END) ? HS_POL : ~HS_POL;
      lcd_vs      = (v_cnt < VS_END) ? VS_POL : ~VS_POL;
      lcd_de      = de_h && de_v;
      frame_start = (h_cnt == '0) && (v_cnt == '0);
      if (win_h && win_v) lcd_rgb = pixel_data;
      else if (lcd_de)    lcd_rgb = BORDER;
      if (rq_h && win_v) begin
        data_req = 1'b1;
        req_x    = h_cnt - RQ0;
        req_y    = v_cnt - WY0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Testbench for lcd_timing_gen on a small raster: H 2/3/8/2, V 1/2/4/1,
// 4x2 window (X0=7, Y0=4), REQ_LEAD=1, RST_CYCLES=4, active-low syncs.
module tb_lcd_timing_gen;

  localparam int          CW     = 5;
  localparam logic [15:0] BORDER = 16'h00F0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [15:0]   pixel_data = '0;
  logic          data_req, frame_start, lcd_hs, lcd_vs, lcd_de;
  logic          lcd_clk, lcd_rst, lcd_bl;
  logic [CW-1:0] req_x, req_y;
  logic [15:0]   lcd_rgb;

  int tests = 0;
  int fails = 0;
  int pos   = 0;

  lcd_timing_gen #(
    .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
    .WIN_W(4), .WIN_H(2), .REQ_LEAD(1), .HS_POL(1'b0), .VS_POL(1'b0),
    .DATA_W(16), .BORDER(BORDER), .RST_CYCLES(4), .CNT_W(CW)
  ) dut (
    .lcd_pclk(clk), .rst_n(rst_n), .enable(enable), .pixel_data(pixel_data),
    .data_req(data_req), .req_x(req_x), .req_y(req_y),
    .frame_start(frame_start), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs),
    .lcd_de(lcd_de), .lcd_rgb(lcd_rgb), .lcd_clk(lcd_clk),
    .lcd_rst(lcd_rst), .lcd_bl(lcd_bl)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pix(input int x, input int y);
    return 16'hC000 | 16'((y << 5) | x);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Upstream source: answers each request one cycle later
  always @(posedge clk)
    pixel_data <= data_req ? pix(int'(req_x), int'(req_y)) : 16'h0BAD;

  // Scoreboard: window pixel follows its request; 8 requests per frame
  logic        rst_q = 1'b0;
  logic        prev_req = 1'b0;
  logic [15:0] prev_val = '0;
  bit          started = 0;
  int          req_cnt = 0;
  always @(posedge clk) rst_q <= rst_n;
  always @(negedge clk) begin
    if (!rst_q) begin
      prev_req = 1'b0;
      started  = 0;
      req_cnt  = 0;
    end else begin
      if (prev_req) chk("sb_pixel", int'(lcd_rgb), int'(prev_val));
      if (frame_start) begin
        if (started) chk("reqs_per_frame", req_cnt, 8);
        started = 1;
        req_cnt = 0;
      end
      if (data_req) req_cnt++;
      prev_req = data_req;
      prev_val = pix(int'(req_x), int'(req_y));
    end
  end

  // Step one clock; inputs and checks happen 1 time unit after the edge
  task automatic adv();
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic adv_to(input int target);
    while (pos < target) adv();
  endtask

  typedef struct {
    int v, h;
    int hs, vs, de, req, rx, ry;
    int sel; // 0: black, 1: border, 2: window pixel
  } rec_t;

  rec_t tbl[$];

  task automatic add(input int v, h, hs, vs, de, req, rx, ry, sel);
    rec_t r;
    r.v = v; r.h = h; r.hs = hs; r.vs = vs; r.de = de;
    r.req = req; r.rx = rx; r.ry = ry; r.sel = sel;
    tbl.push_back(r);
  endtask

  initial begin
    // v  h  hs vs de rq rx ry sel  (sorted by raster position)
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 2, 1, 0, 0, 0, 0, 0, 0);
    add(0,14, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(3, 4, 1, 1, 0, 0, 0, 0, 0);
    add(3, 5, 1, 1, 1, 0, 0, 0, 1);
    add(3, 7, 1, 1, 1, 0, 0, 0, 1);
    add(3,12, 1, 1, 1, 0, 0, 0, 1);
    add(3,13, 1, 1, 0, 0, 0, 0, 0);
    add(4, 1, 0, 1, 0, 0, 0, 0, 0);
    add(4, 4, 1, 1, 0, 0, 0, 0, 0);
    add(4, 5, 1, 1, 1, 0, 0, 0, 1);
    add(4, 6, 1, 1, 1, 1, 0, 0, 1);
    add(4, 7, 1, 1, 1, 1, 1, 0, 2);
    add(4, 8, 1, 1, 1, 1, 2, 0, 2);
    add(4, 9, 1, 1, 1, 1, 3, 0, 2);
    add(4,10, 1, 1, 1, 0, 0, 0, 2);
    add(4,11, 1, 1, 1, 0, 0, 0, 1);
    add(4,12, 1, 1, 1, 0, 0, 0, 1);
    add(4,13, 1, 1, 0, 0, 0, 0, 0);
    add(5, 6, 1, 1, 1, 1, 0, 1, 1);
    add(5, 9, 1, 1, 1, 1, 3, 1, 2);
    add(5,10, 1, 1, 1, 0, 0, 0, 2);
    add(6, 7, 1, 1, 1, 0, 0, 0, 1);
    add(7, 8, 1, 1, 0, 0, 0, 0, 0);
    add(7,14, 1, 1, 0, 0, 0, 0, 0);

    // Reset state
    repeat (3) adv();
    chk("rst_lcd_rst", lcd_rst, 0);
    chk("rst_bl", lcd_bl, 0);
    chk("rst_de", lcd_de, 0);
    chk("rst_req", data_req, 0);
    chk("rst_hs_idle", lcd_hs, 1);
    chk("rst_vs_idle", lcd_vs, 1);
    chk("rst_fs", frame_start, 0);
    chk("rst_rgb", int'(lcd_rgb), 0);

    // Release: lcd_rst low for 4 cycles, RUN on the next
    rst_n = 1'b1; enable = 1'b1;
    adv(); chk("pwr_rst_c1", lcd_rst, 0);
    adv(); adv(); chk("pwr_rst_c3", lcd_rst, 0);
    adv(); chk("pwr_rst_c4", lcd_rst, 1);
    chk("pwr_fs_c4", frame_start, 0);
    chk("pwr_bl_c4", lcd_bl, 0);
    adv(); chk("first_fs", frame_start, 1);
    chk("first_bl", lcd_bl, 1);

    // Table-driven walk through frame 1
    pos = 0;
    foreach (tbl[i]) begin
      string t;
      int    exp_rgb;
      adv_to(tbl[i].v * 15 + tbl[i].h);
      t = $sformatf("v%0d_h%0d", tbl[i].v, tbl[i].h);
      exp_rgb = (tbl[i].sel == 2) ? int'(pix(tbl[i].h - 7, tbl[i].v - 4)) :
                (tbl[i].sel == 1) ? int'(BORDER) : 0;
      chk({t, "_hs"}, lcd_hs, tbl[i].hs);
      chk({t, "_vs"}, lcd_vs, tbl[i].vs);
      chk({t, "_de"}, lcd_de, tbl[i].de);
      chk({t, "_req"}, data_req, tbl[i].req);
      chk({t, "_rx"}, int'(req_x), tbl[i].rx);
      chk({t, "_ry"}, int'(req_y), tbl[i].ry);
      chk({t, "_rgb"}, int'(lcd_rgb), exp_rgb);
    end

    // Back-to-back frame: no idle gap after (14,7)
    adv_to(120);
    chk("b2b_fs", frame_start, 1);
    chk("b2b_bl", lcd_bl, 1);

    // Drop enable at v=2: the frame still completes
    pos = 0;
    adv_to(30); enable = 1'b0;
    adv_to(66); chk("drop_req_v4h6", data_req, 1);
    adv_to(98); chk("drop_de_v6h8", lcd_de, 1);
    adv_to(119);
    adv(); chk("stop_fs", frame_start, 0);
    chk("stop_hs", lcd_hs, 1);
    chk("stop_vs", lcd_vs, 1);
    chk("stop_de", lcd_de, 0);
    repeat (3) adv();
    chk("idle_fs", frame_start, 0);
    chk("idle_req", data_req, 0);
    enable = 1'b1;
    adv(); chk("restart_fs", frame_start, 1);

    // Reset mid-window: everything drops at that edge
    pos = 0;
    adv_to(68);
    chk("pre_rst_req", data_req, 1);
    chk("pre_rst_de", lcd_de, 1);
    rst_n = 1'b0;
    adv();
    chk("mid_rst_req", data_req, 0);
    chk("mid_rst_de", lcd_de, 0);
    chk("mid_rst_lcd_rst", lcd_rst, 0);
    chk("mid_rst_bl", lcd_bl, 0);
    chk("mid_rst_rgb", int'(lcd_rgb), 0);

    // Recover with enable low: no frame, backlight stays off
    rst_n = 1'b1; enable = 1'b0;
    repeat (4) adv();
    chk("rec_lcd_rst", lcd_rst, 1);
    repeat (3) adv();
    chk("rec_fs", frame_start, 0);
    chk("rec_bl", lcd_bl, 0);
    enable = 1'b1;
    adv(); chk("rec_first_fs", frame_start, 1);
    repeat (120) adv();
    chk("rec_b2b_fs", frame_start, 1);
    repeat (3) adv();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Parametrised RGB LCD timing generator with a centred input window. It produces HS/VS/DE, drives the panel pixel bus, and issues pixel requests to the upstream frame source (FIFO or DDR reader) a configurable number of cycles ahead of display. Pixels outside the window show a constant border colour. It also sequences panel reset and backlight, and supports a clean start/stop at frame boundaries. It sits between the frame-buffer read path and the RGB panel pins, and replaces the fixed-timing driver.

## Interface
Parameters:
- H_SYNC, 128 — HS width, pixel clocks
- H_BACK, 88 — horizontal back porch
- H_DISP, 800 — active pixels per line
- H_FRONT, 40 — horizontal front porch
- V_SYNC, 2 — VS width, lines
- V_BACK, 33 — vertical back porch
- V_DISP, 480 — active lines
- V_FRONT, 10 — vertical front porch
- WIN_W, 640 — input image width; must be ≤ H_DISP
- WIN_H, 480 — input image height; must be ≤ V_DISP
- REQ_LEAD, 1 — cycles from data_req to pixel consumption; 1..4, and ≤ H_SYNC+H_BACK
- HS_POL, 1 — HS level during sync
- VS_POL, 1 — VS level during sync
- DATA_W, 16 — pixel width (RGB565 default)
- BORDER, 0 — colour outside the window
- RST_CYCLES, 1024 — lcd_rst low time after reset release
- CNT_W, 12 — counter width; must satisfy 2^CNT_W > H_TOTAL and 2^CNT_W > V_TOTAL

Ports:
- lcd_pclk  in  1  pixel clock; only clock
- rst_n  in  1  synchronous, active-low reset
- enable  in  1  run request; sampled only at frame boundary
- pixel_data  in  DATA_W  pixel answering the data_req issued REQ_LEAD cycles earlier
- data_req  out  1  request next window pixel
- req_x  out  CNT_W  window column of current request, 0 when idle
- req_y  out  CNT_W  window row of current request, 0 when idle
- frame_start  out  1  one-cycle pulse at start of each frame
- lcd_hs, lcd_vs, lcd_de  out  1  panel sync and data-enable
- lcd_rgb  out  DATA_W  panel pixel bus
- lcd_clk  out  1  equals lcd_pclk
- lcd_rst  out  1  panel reset, active low
- lcd_bl  out  1  backlight enable

## Operation
- Derived constants:
  - H_TOTAL = sum of the H parameters; V_TOTAL = sum of the V parameters.
  - HA = H_SYNC+H_BACK; VA = V_SYNC+V_BACK.
  - X0 = HA+(H_DISP−WIN_W)/2; Y0 = VA+(V_DISP−WIN_H)/2. Both use floor division.
- Counters h_cnt and v_cnt:
  - h_cnt wraps at H_TOTAL−1.
  - v_cnt increments when h_cnt wraps, and itself wraps at V_TOTAL−1.
  - Counters advance only in RUN.
- State machine, states PWRUP, IDLE, RUN:
  - PWRUP → IDLE once the lcd_rst counter reaches RST_CYCLES.
  - IDLE → RUN when enable=1. Counters start from 0,0.
  - RUN → IDLE when the last pixel of a frame (H_TOTAL−1, V_TOTAL−1) completes with enable=0. Counters are then held at 0.
  - A mid-frame drop of enable has no effect until the frame ends.
- Decode (combinational from registered counters, and only in RUN):
  - lcd_hs = HS_POL while h_cnt < H_SYNC, else ~HS_POL. Same rule for lcd_vs with V_SYNC and VS_POL.
  - lcd_de = 1 when h_cnt ∈ [HA, HA+H_DISP) and v_cnt ∈ [VA, VA+V_DISP).
  - In-window = h_cnt ∈ [X0, X0+WIN_W) and v_cnt ∈ [Y0, Y0+WIN_H).
  - lcd_rgb = pixel_data when in-window; BORDER when lcd_de=1 outside the window; 0 when lcd_de=0.
  - data_req = 1 when h_cnt ∈ [X0−REQ_LEAD, X0+WIN_W−REQ_LEAD) and v_cnt ∈ [Y0, Y0+WIN_H).
  - req_x = h_cnt−(X0−REQ_LEAD) and req_y = v_cnt−Y0 while data_req=1; otherwise both are 0.
  - frame_start = 1 when in RUN at h_cnt=0, v_cnt=0.
- Outputs in PWRUP and IDLE:
  - lcd_hs = ~HS_POL, lcd_vs = ~VS_POL.
  - lcd_de, data_req, frame_start, lcd_rgb all 0.
- Power sequencing:
  - lcd_rst is held 0 for RST_CYCLES cycles after rst_n goes high, then 1.
  - lcd_bl becomes 1 on the first frame_start and stays 1 until reset.

## Timing
- rst_n=0 at a clock edge causes, at that edge:
  - state = PWRUP, counters = 0, lcd_rst = 0, lcd_bl = 0, all decode outputs at their IDLE values.
  - This holds even when reset arrives mid-frame; there is no drain.
- Request latency:
  - Exactly REQ_LEAD cycles from a data_req to the cycle where lcd_rgb shows the corresponding pixel.
  - Exactly WIN_W requests per window line, and WIN_W·WIN_H per frame.
- Edge cases:
  - WIN_W = H_DISP gives X0 = HA; data_req then leads lcd_de by REQ_LEAD.
  - Window rows produce no requests on non-window lines.
- The first IDLE→RUN transition gives frame_start in the first RUN cycle (counters 0,0).
- A back-to-back frame with enable=1 has no idle gap: h_cnt/v_cnt go from (H_TOTAL−1, V_TOTAL−1) straight to (0,0).

## Test plan
Small configuration: H 2/3/8/2, V 1/2/4/1, WIN 4×2, REQ_LEAD=1, RST_CYCLES=4. This gives H_TOTAL=15, V_TOTAL=8, X0=7, Y0=4.
- Reset, release, enable=1 → lcd_rst rises after 4 cycles; next cycle RUN, frame_start=1, lcd_bl=1 from that cycle on.
- Line v_cnt=4 → data_req high for h_cnt 6..9 with req_x 0..3, req_y=0; lcd_de high for h 5..12; lcd_rgb=BORDER at h 5,6,11,12 and =pixel_data at h 7..10.
- Line v_cnt=3 → lcd_de high for h 5..12, data_req=0, lcd_rgb=BORDER throughout the DE period.
- HS_POL=0, VS_POL=0 → lcd_hs low for h 0..1, lcd_vs low on line 0, both high elsewhere.
- Drop enable at v_cnt=2 → frame runs to (14,7), then IDLE with counters 0 and no frame_start. Re-raise enable → frame_start on the next cycle.
- Assert rst_n=0 at h=8, v=4 → on that edge: data_req=0, lcd_de=0, lcd_rst=0, lcd_bl=0.
- Scoreboard check across all cases: lcd_rgb in each window pixel equals the value returned REQ_LEAD cycles after its request; 8 requests per frame.
